// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and frame constants shared by the receiver and transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVERSAMPLE  = 16;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for asynchronous inputs, resets to the idle-high level
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  // shift the async input through two flops to settle metastability
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], d};
  assign q = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, 8N1 by default; UART_RX_PARITY_EN adds an even-parity bit and parity_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            frame_err
);
  localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
  state_t          state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d, dout_q, dout_d;
  logic            done_q, done_d, ferr_q, ferr_d, tick_q;
  logic            rx_s, s_tick;
`ifdef UART_RX_PARITY_EN
  logic            pbad_q, pbad_d, perr_q, perr_d;
`endif
  uart_sync2 u_sync (.clk(clk), .reset(reset), .d(rx), .q(rx_s));
  assign s_tick = tick & ~tick_q;
  // edge-detect the baud square wave so counters advance once per tick
  always_ff @(posedge clk or negedge reset)
    if (!reset) tick_q <= 1'b0;
    else        tick_q <= tick;
  // frame state and output registers; an active reset aborts any frame in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  // next-state: re-centre on the start bit, then sample each bit at its middle
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = perr_q;
`endif
    unique case (state_q)
      IDLE:
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      START:
        if (s_tick) begin
          if (s_q == 4'(OVERSAMPLE / 2 - 1)) begin
            state_d = rx_s ? IDLE : DATA;
            s_d     = '0;
            n_d     = '0;
          end else s_d = s_q + 4'd1;
        end
      DATA:
        if (s_tick) begin
          if (s_q == 4'(OVERSAMPLE - 1)) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = n_q == NW'(DBIT - 1) ? PARITY : DATA;
`else
            state_d = n_q == NW'(DBIT - 1) ? STOP : DATA;
`endif
            n_d = n_q + NW'(1);
          end else s_d = s_q + 4'd1;
        end
`ifdef UART_RX_PARITY_EN
      PARITY:
        if (s_tick) begin
          if (s_q == 4'(OVERSAMPLE - 1)) begin
            pbad_d  = ^{b_q, rx_s};
            s_d     = '0;
            state_d = STOP;
          end else s_d = s_q + 4'd1;
        end
`endif
      STOP:
        if (s_tick) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            s_d     = '0;
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            perr_d  = pbad_q;
`endif
          end else s_d = s_q + 4'd1;
        end
      default: state_d = IDLE;
    endcase
  end
  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with a dvsr=3 baud generator (8 clk per tick, 128 clk per bit)
module tb_uart_rx;
  import uart_pkg::*;
  logic clk = 1'b0, reset = 1'b0, tick = 1'b0, rx = 1'b1;
  logic [7:0] dout;
  logic rx_done_tick, frame_err;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif
  logic [1:0] bg_cnt = 2'd0;
  logic [7:0] got_b[$];
  logic got_f[$];
  logic got_p[$];
  int vecs = 0, errs = 0;
  uart_rx dut (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx), .dout(dout),
    .rx_done_tick(rx_done_tick),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  // baud generator: tick toggles every 4 clk
  always @(posedge clk) begin
    bg_cnt <= bg_cnt + 2'd1;
    if (bg_cnt == 2'd3) tick <= ~tick;
  end
  // record every completed frame
  always @(negedge clk)
    if (rx_done_tick) begin
      got_b.push_back(dout);
      got_f.push_back(frame_err);
`ifdef UART_RX_PARITY_EN
      got_p.push_back(parity_err);
`else
      got_p.push_back(1'b0);
`endif
    end
  task automatic send_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
  endtask
  // par < 0: no parity bit; bad stop held low only long enough to be sampled
  task automatic send_frame(input logic [7:0] d, input logic stop, input int par);
    send_bit(1'b0, 128);
    for (int i = 0; i < 8; i++) send_bit(d[i], 128);
    if (par >= 0) send_bit(par[0], 128);
    if (stop) send_bit(1'b1, 128);
    else begin
      send_bit(1'b0, 96);
      send_bit(1'b1, 32);
    end
  endtask
  task automatic clear_log();
    got_b.delete();
    got_f.delete();
    got_p.delete();
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (dout !== 8'h00) begin errs++; $display("FAIL reset_dout got %h want 00", dout); end
    vecs++; if (rx_done_tick !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", rx_done_tick); end
    vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    vecs++; if (dut.state_q !== IDLE) begin errs++; $display("FAIL reset_state got %0d want %0d", int'(dut.state_q), int'(IDLE)); end
    @(negedge clk) reset = 1'b1;
    repeat (20) @(posedge clk);
  endtask
  task automatic test_single();
    clear_log();
    send_frame(8'h55, 1'b1, -1);
    send_bit(1'b1, 64);
    vecs++; if (got_b.size() !== 1) begin errs++; $display("FAIL single_count got %0d want 1", got_b.size()); end
    vecs++; if (got_b[0] !== 8'h55) begin errs++; $display("FAIL single_dout got %h want 55", got_b[0]); end
    vecs++; if (got_f[0] !== 1'b0) begin errs++; $display("FAIL single_ferr got %b want 0", got_f[0]); end
    vecs++; if (rx_done_tick !== 1'b0) begin errs++; $display("FAIL single_pulse_end got %b want 0", rx_done_tick); end
  endtask
  task automatic test_back_to_back();
    clear_log();
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h0F, 1'b1, -1);
    send_bit(1'b1, 64);
    vecs++; if (got_b.size() !== 2) begin errs++; $display("FAIL b2b_count got %0d want 2", got_b.size()); end
    vecs++; if (got_b[0] !== 8'hA3) begin errs++; $display("FAIL b2b_first got %h want a3", got_b[0]); end
    vecs++; if (got_b[1] !== 8'h0F) begin errs++; $display("FAIL b2b_second got %h want 0f", got_b[1]); end
    vecs++; if ({got_f[0], got_f[1]} !== 2'b00) begin errs++; $display("FAIL b2b_ferr got %b%b want 00", got_f[0], got_f[1]); end
  endtask
  task automatic test_glitch();
    clear_log();
    send_bit(1'b0, 24);
    send_bit(1'b1, 300);
    vecs++; if (got_b.size() !== 0) begin errs++; $display("FAIL glitch_count got %0d want 0", got_b.size()); end
    vecs++; if (dut.state_q !== IDLE) begin errs++; $display("FAIL glitch_state got %0d want %0d", int'(dut.state_q), int'(IDLE)); end
    vecs++; if (dout !== 8'h0F) begin errs++; $display("FAIL glitch_dout got %h want 0f", dout); end
    send_frame(8'h3C, 1'b1, -1);
    send_bit(1'b1, 64);
    vecs++; if (got_b.size() !== 1) begin errs++; $display("FAIL glitch_next_count got %0d want 1", got_b.size()); end
    vecs++; if (got_b[0] !== 8'h3C) begin errs++; $display("FAIL glitch_next_dout got %h want 3c", got_b[0]); end
  endtask
  task automatic test_frame_err();
    clear_log();
    send_frame(8'hFF, 1'b0, -1);
    send_bit(1'b1, 200);
    vecs++; if (got_b.size() !== 1) begin errs++; $display("FAIL ferr_count got %0d want 1", got_b.size()); end
    vecs++; if (got_b[0] !== 8'hFF) begin errs++; $display("FAIL ferr_dout got %h want ff", got_b[0]); end
    vecs++; if (got_f[0] !== 1'b1) begin errs++; $display("FAIL ferr_flag got %b want 1", got_f[0]); end
    vecs++; if (frame_err !== 1'b1) begin errs++; $display("FAIL ferr_hold got %b want 1", frame_err); end
    clear_log();
    send_frame(8'h12, 1'b1, -1);
    send_bit(1'b1, 64);
    vecs++; if (got_b[0] !== 8'h12) begin errs++; $display("FAIL ferr_next_dout got %h want 12", got_b[0]); end
    vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL ferr_clear got %b want 0", frame_err); end
  endtask
  task automatic test_reset_mid();
    logic [7:0] d;
    clear_log();
    d = 8'hB5;
    send_bit(1'b0, 128);
    for (int i = 0; i < 3; i++) send_bit(d[i], 128);
    send_bit(d[3], 64);
    @(negedge clk) reset = 1'b0;
    #1;
    vecs++; if (dout !== 8'h00) begin errs++; $display("FAIL rstmid_dout got %h want 00", dout); end
    vecs++; if ({rx_done_tick, frame_err} !== 2'b00) begin errs++; $display("FAIL rstmid_flags got %b want 00", {rx_done_tick, frame_err}); end
    vecs++; if (dut.state_q !== IDLE) begin errs++; $display("FAIL rstmid_state got %0d want %0d", int'(dut.state_q), int'(IDLE)); end
    rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (200) @(posedge clk);
    vecs++; if (got_b.size() !== 0) begin errs++; $display("FAIL rstmid_nopulse got %0d want 0", got_b.size()); end
    send_frame(8'h81, 1'b1, -1);
    send_bit(1'b1, 64);
    vecs++; if (got_b.size() !== 1) begin errs++; $display("FAIL rstmid_next_count got %0d want 1", got_b.size()); end
    vecs++; if (got_b[0] !== 8'h81) begin errs++; $display("FAIL rstmid_next_dout got %h want 81", got_b[0]); end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_log();
    send_frame(8'h07, 1'b1, 1);
    send_bit(1'b1, 64);
    vecs++; if (got_b[0] !== 8'h07) begin errs++; $display("FAIL par_ok_dout got %h want 07", got_b[0]); end
    vecs++; if (got_p[0] !== 1'b0) begin errs++; $display("FAIL par_ok_perr got %b want 0", got_p[0]); end
    clear_log();
    send_frame(8'h07, 1'b1, 0);
    send_bit(1'b1, 64);
    vecs++; if (got_b[0] !== 8'h07) begin errs++; $display("FAIL par_bad_dout got %h want 07", got_b[0]); end
    vecs++; if (got_p[0] !== 1'b1) begin errs++; $display("FAIL par_bad_perr got %b want 1", got_p[0]); end
    vecs++; if (parity_err !== 1'b1) begin errs++; $display("FAIL par_hold got %b want 1", parity_err); end
  endtask
`endif
  initial begin
    test_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver consuming the 16×-oversampling tick from the baud generator. Recovers 8N1 serial frames from the `rx` line, LSB first. Presents each received byte on `dout` with a one-clock `rx_done_tick`. Sits between the external RX pin and the byte-level consumer (FIFO or command parser), and shares `tick` with the transmitter.

## Interface
- `DBIT`, 8, data bits per frame
- `SB_TICK`, 16, sample ticks spent in the stop bit (16 = 1 stop bit)
- `clk` input 1 — system clock; all logic on rising edge
- `reset` input 1 — asynchronous, active-low; all state cleared while low
- `tick` input 1 — baud generator output; a toggling square wave, each rising edge = one sample tick (16 per bit)
- `rx` input 1 — serial line, asynchronous, idle high
- `dout` output DBIT — last received byte
- `rx_done_tick` output 1 — one-clk pulse when `dout` updates
- `frame_err` output 1 — last frame had stop bit sampled 0
- `parity_err` output 1 — last frame failed parity (only when `UART_RX_PARITY_EN` is defined)

## Operation
- `rx` passes through a 2-flop synchronizer; all decisions use the synchronized value.
- `tick` is registered once; `s_tick = tick & ~tick_q` (one-clk pulse per rising edge). Counters advance only on `s_tick`.
- Registers: state, 4-bit sample counter `s`, 3-bit bit counter `n` (width clog2(DBIT)), shift register `b` (DBIT).
- IDLE: on synchronized `rx`==0 → START, `s`=0. Falling-edge detection runs every clk, not only on `s_tick`.
- START: on `s_tick` with `s`==7 (mid start bit): if `rx`==0 → DATA, `s`=0, `n`=0; else glitch → IDLE, no outputs change. Otherwise `s`++.
- DATA: on `s_tick` with `s`==15: `b` = {rx, b[DBIT-1:1]}, `s`=0; if `n`==DBIT-1 → STOP (or PARITY), else `n`++.
- PARITY (macro only): on `s_tick` with `s`==15, even-parity check of `b` ^ rx → STOP.
- STOP: on `s_tick` with `s`==SB_TICK-1: `dout`=`b`, `frame_err`=~rx, `parity_err` latched, `rx_done_tick`=1 next clk, → IDLE.
- A frame with a bad stop bit still completes and pulses `rx_done_tick`; `dout` carries the shifted byte.
- `frame_err` and `parity_err` hold until the next `rx_done_tick` overwrites them.
- No back-pressure: a new frame overwrites `dout`, and the consumer must take it on `rx_done_tick`.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0, state IDLE, counters 0, synchronizer flops 1, `tick_q` 0.
- `rx` to FSM: 2 clk synchronizer delay.
- `tick` rising edge to `s_tick`: 1 clk.
- `rx_done_tick` asserts exactly 1 clk after the `s_tick` that ends STOP, and lasts 1 clk.
- Frame duration: 16 (start) − 8 + 16·DBIT + SB_TICK sample ticks from the detected start edge to done. This is 8 short of a full frame because start is re-centred; back-to-back frames are accepted immediately, since IDLE is re-entered mid stop bit.
- Reset mid-frame: immediate return to IDLE and reset values, no pulse. The next falling edge after release starts a fresh frame.

## Configuration
- `UART_RX_PARITY_EN` defined: adds the PARITY state (even parity, 1 bit after data), the `parity_err` port, and extends the frame by 16 ticks.
- Undefined: 8N1 only, no PARITY state, no `parity_err` port.

## Structure
- Package `uart_pkg`: state encoding (IDLE, START, DATA, PARITY, STOP), default `DBIT`=8, `SB_TICK`=16, and `OVERSAMPLE`=16 constant. The package is shared with the transmitter.
- Sub-module `uart_sync2`: a 2-flop synchronizer with async active-low reset value 1, reused by the transmitter side for CTS.

## Test plan
Bench setup: clk period 10 ns, baud generator dvsr=3, giving 8 clk per sample tick and 128 clk per bit.
- Frame 0x55, stop=1 → one `rx_done_tick`, `dout`=0x55, `frame_err`=0.
- Back-to-back frames 0xA3 then 0x0F with no idle gap → two pulses, `dout`=0xA3 then 0x0F, `frame_err`=0 both.
- `rx` low for 3 sample ticks then high (glitch) → no `rx_done_tick`, FSM in IDLE, `dout` unchanged. A following 0x3C is received correctly.
- Data 0xFF with stop bit 0 → pulse, `dout`=0xFF, `frame_err`=1. A subsequent good 0x12 → `frame_err`=0.
- Assert `reset` during the 4th data bit → all outputs 0 within the same clk. After release, frame 0x81 → `dout`=0x81.
- With `UART_RX_PARITY_EN` defined: 0x07 with parity bit 1 → `parity_err`=0. 0x07 with parity bit 0 → `parity_err`=1, `dout`=0x07.
